// File: rtl/load_store_sequencer.sv
// load_store_sequencer
//   Multi-cycle load/store sequencer for the LD/ST instruction group. It latches
//   the instruction fields on DECODE, runs one or two bus beats starting in the
//   EXECUTE cycle with a wait-state handshake and timeout, and issues register
//   write enables on COMMIT.
//
//   Inputs : CLK, RESET (async, active high), DECODE/EXECUTE/COMMIT phase strobes,
//            GROUP_LDS, OPF[1:0], MODEF[2:0], PAIR, BYTE, MEM_RDY.
//   Outputs: STALL, RDX, WRX, BYTEX, ADDR_BUSX[1:0], ALUA_SRCX[2:0],
//            BEAT_OFS[ADDR_WIDTH-1:0], REGA_WEN, REGB_WEN, REGA_PLUS1, BUS_ERR.
//
//   All outputs are decoded combinationally from the state register, the latched
//   fields and MEM_RDY. They are all zero whenever the block is idle, so an
//   asynchronous reset clears every output in the same cycle.
module load_store_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int WAIT_MAX   = 15,
  parameter int PAIR_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  DECODE,
  input  logic                  EXECUTE,
  input  logic                  COMMIT,
  input  logic                  GROUP_LDS,
  input  logic [1:0]            OPF,
  input  logic [2:0]            MODEF,
  input  logic                  PAIR,
  input  logic                  BYTE,
  input  logic                  MEM_RDY,
  output logic                  STALL,
  output logic                  RDX,
  output logic                  WRX,
  output logic                  BYTEX,
  output logic [1:0]            ADDR_BUSX,
  output logic [2:0]            ALUA_SRCX,
  output logic [ADDR_WIDTH-1:0] BEAT_OFS,
  output logic                  REGA_WEN,
  output logic                  REGB_WEN,
  output logic                  REGA_PLUS1,
  output logic                  BUS_ERR
);

  localparam logic [1:0] LDSOPF_LD = 2'd0;
  localparam logic [1:0] LDSOPF_ST = 2'd1;

  localparam logic [2:0] MODE_LDS_REG_REG     = 3'd0;
  localparam logic [2:0] MODE_LDS_HERE        = 3'd1;
  localparam logic [2:0] MODE_LDS_REG_REG_DEC = 3'd2;
  localparam logic [2:0] MODE_LDS_REG_REG_INC = 3'd3;
  localparam logic [2:0] MODE_LDS_REG_FP      = 3'd4;
  localparam logic [2:0] MODE_LDS_REG_SP      = 3'd5;
  localparam logic [2:0] MODE_LDS_REG_RS      = 3'd6;

  // Zero is reserved as "no source" so an idle block drives all-zero selects.
  localparam logic [1:0] ADDR_BUSX_ALUB_DATA = 2'd1;
  localparam logic [1:0] ADDR_BUSX_HERE      = 2'd2;
  localparam logic [1:0] ADDR_BUSX_ALU_R     = 2'd3;

  localparam logic [2:0] ALUA_SRCX_ZERO      = 3'd0;
  localparam logic [2:0] ALUA_SRCX_TWO       = 3'd1;
  localparam logic [2:0] ALUA_SRCX_MINUS_TWO = 3'd2;
  localparam logic [2:0] ALUA_SRCX_U5_0      = 3'd3;

  localparam logic [ADDR_WIDTH-1:0] OFS_TWO  = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [ADDR_WIDTH-1:0] OFS_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [7:0]            WAIT_LIM = 8'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT1 = 3'd1,
    S_WAIT1 = 3'd2,
    S_BEAT2 = 3'd3,
    S_WAIT2 = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       lds_q, lds_d;      // a load/store instruction is latched
  logic [1:0] opf_q, opf_d;
  logic [2:0] mode_q, mode_d;
  logic       pair_q, pair_d;
  logic       byte_q, byte_d;
  logic       pair2_q, pair2_d;  // the second beat was executed

  state_t     cur_s;
  logic       is_ld_s, is_st_s, incdec_s, do_pair_s;
  logic [1:0] mode_abus_s;
  logic [2:0] mode_alua_s;

  // State and latched-field registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
      lds_q      <= 1'b0;
      opf_q      <= 2'd0;
      mode_q     <= 3'd0;
      pair_q     <= 1'b0;
      byte_q     <= 1'b0;
      pair2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lds_q      <= lds_d;
      opf_q      <= opf_d;
      mode_q     <= mode_d;
      pair_q     <= pair_d;
      byte_q     <= byte_d;
      pair2_q    <= pair2_d;
    end
  end

  // Addressing-mode decode of the latched mode field.
  always_comb begin
    mode_abus_s = ADDR_BUSX_ALUB_DATA;
    mode_alua_s = ALUA_SRCX_ZERO;
    case (mode_q)
      MODE_LDS_REG_REG:     begin mode_alua_s = ALUA_SRCX_ZERO;      mode_abus_s = ADDR_BUSX_ALUB_DATA; end
      MODE_LDS_HERE:        begin mode_alua_s = ALUA_SRCX_ZERO;      mode_abus_s = ADDR_BUSX_HERE;      end
      MODE_LDS_REG_REG_DEC: begin mode_alua_s = ALUA_SRCX_MINUS_TWO; mode_abus_s = ADDR_BUSX_ALU_R;     end
      MODE_LDS_REG_REG_INC: begin mode_alua_s = ALUA_SRCX_TWO;       mode_abus_s = ADDR_BUSX_ALUB_DATA; end
      MODE_LDS_REG_FP,
      MODE_LDS_REG_SP,
      MODE_LDS_REG_RS:      begin mode_alua_s = ALUA_SRCX_U5_0;      mode_abus_s = ADDR_BUSX_ALU_R;     end
      default:              begin mode_alua_s = ALUA_SRCX_ZERO;      mode_abus_s = ADDR_BUSX_ALUB_DATA; end
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lds_d      = lds_q;
    opf_d      = opf_q;
    mode_d     = mode_q;
    pair_d     = pair_q;
    byte_d     = byte_q;
    pair2_d    = pair2_q;

    STALL      = 1'b0;
    RDX        = 1'b0;
    WRX        = 1'b0;
    BYTEX      = 1'b0;
    ADDR_BUSX  = 2'd0;
    ALUA_SRCX  = 3'd0;
    BEAT_OFS   = OFS_ZERO;
    REGA_WEN   = 1'b0;
    REGB_WEN   = 1'b0;
    REGA_PLUS1 = 1'b0;
    BUS_ERR    = 1'b0;

    is_ld_s   = (opf_q == LDSOPF_LD);
    is_st_s   = (opf_q == LDSOPF_ST);
    incdec_s  = (mode_q == MODE_LDS_REG_REG_INC) || (mode_q == MODE_LDS_REG_REG_DEC);
    do_pair_s = (PAIR_EN != 0) && pair_q && !byte_q;

    // The EXECUTE cycle itself is beat 1, so a zero-wait access completes
    // without stalling: an armed IDLE is treated as BEAT1 in that cycle.
    if ((state_q == S_IDLE) && lds_q && EXECUTE) begin
      cur_s = S_BEAT1;
    end else begin
      cur_s = state_q;
    end

    // Mode selects stay constant from DECODE until the instruction retires.
    if (lds_q) begin
      ADDR_BUSX = mode_abus_s;
      ALUA_SRCX = mode_alua_s;
    end else begin
      ADDR_BUSX = 2'd0;
      ALUA_SRCX = 3'd0;
    end

    case (cur_s)
      S_IDLE: begin
        wait_cnt_d = 8'd0;
        pair2_d    = 1'b0;
        if (DECODE) begin
          lds_d = GROUP_LDS;
          if (GROUP_LDS) begin
            opf_d  = OPF;
            mode_d = MODEF;
            pair_d = PAIR;
            byte_d = BYTE;
          end else begin
            opf_d  = opf_q;
          end
        end else begin
          lds_d = lds_q;
        end
      end
      S_BEAT1, S_WAIT1, S_BEAT2, S_WAIT2: begin
        RDX   = is_ld_s;
        WRX   = is_st_s;
        BYTEX = byte_q;
        if ((cur_s == S_BEAT2) || (cur_s == S_WAIT2)) begin
          BEAT_OFS   = OFS_TWO;
          REGA_PLUS1 = 1'b1;
        end else begin
          BEAT_OFS   = OFS_ZERO;
          REGA_PLUS1 = 1'b0;
        end
        if (MEM_RDY) begin
          wait_cnt_d = 8'd0;
          if (((cur_s == S_BEAT1) || (cur_s == S_WAIT1)) && do_pair_s) begin
            // Beat 1 of a pair: write Ra now, keep EXECUTE held for beat 2.
            REGA_WEN = is_ld_s;
            STALL    = 1'b1;
            pair2_d  = 1'b1;
            state_d  = S_BEAT2;
          end else begin
            STALL    = 1'b0;
            state_d  = S_DONE;
          end
        end else begin
          STALL = 1'b1;
          if ((cur_s == S_BEAT1) || (cur_s == S_BEAT2)) begin
            wait_cnt_d = 8'd0;
            state_d    = (cur_s == S_BEAT1) ? S_WAIT1 : S_WAIT2;
          end else if ((wait_cnt_q + 8'd1) == WAIT_LIM) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            state_d    = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            state_d    = cur_s;
          end
        end
      end
      S_DONE: begin
        // A pair retires through Ra+1 and moves the pointer by 4 (2 doubled).
        REGA_PLUS1 = pair2_q;
        BEAT_OFS   = (pair2_q && incdec_s) ? OFS_TWO : OFS_ZERO;
        if (COMMIT) begin
          REGA_WEN = is_ld_s;
          REGB_WEN = incdec_s;
          lds_d    = 1'b0;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_DONE;
        end
      end
      S_ERR: begin
        BUS_ERR = 1'b1;
        lds_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        lds_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
module tb_load_store_sequencer;

  localparam logic [1:0] OP_LD = 2'd0;
  localparam logic [1:0] OP_ST = 2'd1;

  localparam logic [2:0] M_RR  = 3'd0;
  localparam logic [2:0] M_HR  = 3'd1;
  localparam logic [2:0] M_DEC = 3'd2;
  localparam logic [2:0] M_INC = 3'd3;
  localparam logic [2:0] M_FP  = 3'd4;

  localparam logic [1:0] AB_ALUB = 2'd1;
  localparam logic [1:0] AB_HERE = 2'd2;
  localparam logic [1:0] AB_ALUR = 2'd3;

  localparam logic [2:0] AL_ZERO = 3'd0;
  localparam logic [2:0] AL_TWO  = 3'd1;
  localparam logic [2:0] AL_M2   = 3'd2;
  localparam logic [2:0] AL_U5   = 3'd3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        DECODE, EXECUTE, COMMIT, GROUP_LDS, PAIR, BYTE, MEM_RDY;
  logic [1:0]  OPF;
  logic [2:0]  MODEF;
  logic        STALL, RDX, WRX, BYTEX, REGA_WEN, REGB_WEN, REGA_PLUS1, BUS_ERR;
  logic [1:0]  ADDR_BUSX;
  logic [2:0]  ALUA_SRCX;
  logic [15:0] BEAT_OFS;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        dec, exe, com, grp;
    logic [1:0]  opf;
    logic [2:0]  mode;
    logic        pr, by, rdy;
    logic [28:0] exp;
  } row_t;

  logic [28:0] sb[$];
  logic [28:0] outs;

  load_store_sequencer #(.ADDR_WIDTH(16), .WAIT_MAX(15), .PAIR_EN(1)) dut (
    .CLK(CLK), .RESET(RESET), .DECODE(DECODE), .EXECUTE(EXECUTE), .COMMIT(COMMIT),
    .GROUP_LDS(GROUP_LDS), .OPF(OPF), .MODEF(MODEF), .PAIR(PAIR), .BYTE(BYTE),
    .MEM_RDY(MEM_RDY), .STALL(STALL), .RDX(RDX), .WRX(WRX), .BYTEX(BYTEX),
    .ADDR_BUSX(ADDR_BUSX), .ALUA_SRCX(ALUA_SRCX), .BEAT_OFS(BEAT_OFS),
    .REGA_WEN(REGA_WEN), .REGB_WEN(REGB_WEN), .REGA_PLUS1(REGA_PLUS1), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  assign outs = {STALL, RDX, WRX, BYTEX, ADDR_BUSX, ALUA_SRCX, BEAT_OFS,
                 REGA_WEN, REGB_WEN, REGA_PLUS1, BUS_ERR};

  function automatic logic [28:0] ev(input logic st, rd, wr, by, input logic [1:0] ab,
                                     input logic [2:0] al, input logic [15:0] ofs,
                                     input logic wa, wb, p1, er);
    ev = {st, rd, wr, by, ab, al, ofs, wa, wb, p1, er};
  endfunction

  function automatic row_t mk(input logic dec, exe, com, grp, input logic [1:0] opf,
                              input logic [2:0] mode, input logic pr, by, rdy,
                              input logic [28:0] exp);
    row_t r;
    r.dec = dec; r.exe = exe; r.com = com; r.grp = grp; r.opf = opf; r.mode = mode;
    r.pr = pr; r.by = by; r.rdy = rdy; r.exp = exp;
    return r;
  endfunction

  // Drive one cycle of stimulus after the falling edge and queue its expectation.
  task automatic drive(input row_t r);
    @(negedge CLK);
    DECODE = r.dec; EXECUTE = r.exe; COMMIT = r.com; GROUP_LDS = r.grp;
    OPF = r.opf; MODEF = r.mode; PAIR = r.pr; BYTE = r.by; MEM_RDY = r.rdy;
    sb.push_back(r.exp);
    #1;
  endtask

  task automatic test_reset();
    logic [28:0] want;
    RESET = 1'b1;
    DECODE = 1'b0; EXECUTE = 1'b0; COMMIT = 1'b0; GROUP_LDS = 1'b0;
    OPF = 2'd0; MODEF = 3'd0; PAIR = 1'b0; BYTE = 1'b0; MEM_RDY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    want = 29'd0;
    checks++;
    if (outs !== want) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", outs, want);
    end
    RESET = 1'b0;
  endtask

  task automatic run_ld_single(input string nm);
    row_t rows[$];
    logic [28:0] want;
    rows.push_back(mk(1, 0, 0, 1, OP_LD, M_RR, 0, 0, 1, 29'd0));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_RR, 0, 0, 1, ev(0, 1, 0, 0, AB_ALUB, AL_ZERO, 16'd0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 1, 0, OP_LD, M_RR, 0, 0, 1, ev(0, 0, 0, 0, AB_ALUB, AL_ZERO, 16'd0, 1, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, OP_LD, M_RR, 0, 0, 1, 29'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      want = sb.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%h exp=%h", nm, i, outs, want);
      end
    end
  endtask

  task automatic test_ld_single();
    run_ld_single("ld_single");
  endtask

  // ST with three wait cycles; a stray DECODE mid-access must be ignored.
  task automatic test_st_wait();
    row_t rows[$];
    logic [28:0] want;
    logic [28:0] w_stall;
    w_stall = ev(1, 0, 1, 0, AB_ALUB, AL_ZERO, 16'd0, 0, 0, 0, 0);
    rows.push_back(mk(1, 0, 0, 1, OP_ST, M_RR, 0, 0, 0, 29'd0));
    rows.push_back(mk(0, 1, 0, 0, OP_ST, M_RR, 0, 0, 0, w_stall));
    rows.push_back(mk(1, 1, 0, 1, OP_LD, M_HR, 0, 0, 0, w_stall));
    rows.push_back(mk(0, 1, 0, 0, OP_ST, M_RR, 0, 0, 0, w_stall));
    rows.push_back(mk(0, 1, 0, 0, OP_ST, M_RR, 0, 0, 1, ev(0, 0, 1, 0, AB_ALUB, AL_ZERO, 16'd0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 1, 0, OP_ST, M_RR, 0, 0, 0, ev(0, 0, 0, 0, AB_ALUB, AL_ZERO, 16'd0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, OP_ST, M_RR, 0, 0, 0, 29'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      want = sb.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL st_wait cycle=%0d got=%h exp=%h", i, outs, want);
      end
    end
  endtask

  task automatic test_pair();
    row_t rows[$];
    logic [28:0] want;
    // LD Ra,(Rb++) pair, zero wait.
    rows.push_back(mk(1, 0, 0, 1, OP_LD, M_INC, 1, 0, 1, 29'd0));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_INC, 1, 0, 1, ev(1, 1, 0, 0, AB_ALUB, AL_TWO, 16'd0, 1, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_INC, 1, 0, 1, ev(0, 1, 0, 0, AB_ALUB, AL_TWO, 16'd2, 0, 0, 1, 0)));
    rows.push_back(mk(0, 0, 1, 0, OP_LD, M_INC, 1, 0, 1, ev(0, 0, 0, 0, AB_ALUB, AL_TWO, 16'd2, 1, 1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, OP_LD, M_INC, 0, 0, 1, 29'd0));
    // LD pair with pre-decrement, one wait cycle in beat 2.
    rows.push_back(mk(1, 0, 0, 1, OP_LD, M_DEC, 1, 0, 1, 29'd0));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_DEC, 1, 0, 1, ev(1, 1, 0, 0, AB_ALUR, AL_M2, 16'd0, 1, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_DEC, 1, 0, 0, ev(1, 1, 0, 0, AB_ALUR, AL_M2, 16'd2, 0, 0, 1, 0)));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_DEC, 1, 0, 1, ev(0, 1, 0, 0, AB_ALUR, AL_M2, 16'd2, 0, 0, 1, 0)));
    rows.push_back(mk(0, 0, 1, 0, OP_LD, M_DEC, 1, 0, 0, ev(0, 0, 0, 0, AB_ALUR, AL_M2, 16'd2, 1, 1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, OP_LD, M_DEC, 0, 0, 0, 29'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      want = sb.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL pair cycle=%0d got=%h exp=%h", i, outs, want);
      end
    end
  endtask

  // MEM_RDY stuck low: 16 stall cycles, one BUS_ERR pulse, COMMIT ignored.
  task automatic test_timeout();
    row_t rows[$];
    logic [28:0] want;
    logic [28:0] w_stall;
    w_stall = ev(1, 1, 0, 0, AB_ALUB, AL_ZERO, 16'd0, 0, 0, 0, 0);
    rows.push_back(mk(1, 0, 0, 1, OP_LD, M_RR, 0, 0, 0, 29'd0));
    for (int k = 0; k < 16; k++) begin
      rows.push_back(mk(0, 1, 0, 0, OP_LD, M_RR, 0, 0, 0, w_stall));
    end
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_RR, 0, 0, 0, ev(0, 0, 0, 0, AB_ALUB, AL_ZERO, 16'd0, 0, 0, 0, 1)));
    rows.push_back(mk(0, 0, 1, 0, OP_LD, M_RR, 0, 0, 0, 29'd0));
    rows.push_back(mk(0, 0, 0, 0, OP_LD, M_RR, 0, 0, 0, 29'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      want = sb.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL timeout cycle=%0d got=%h exp=%h", i, outs, want);
      end
    end
  endtask

  task automatic test_modes();
    row_t rows[$];
    logic [28:0] want;
    // LD Ra,(FP+5) byte with PAIR: single beat.
    rows.push_back(mk(1, 0, 0, 1, OP_LD, M_FP, 1, 1, 1, 29'd0));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_FP, 1, 1, 1, ev(0, 1, 0, 1, AB_ALUR, AL_U5, 16'd0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 1, 0, OP_LD, M_FP, 1, 1, 1, ev(0, 0, 0, 0, AB_ALUR, AL_U5, 16'd0, 1, 0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, OP_LD, M_FP, 0, 0, 1, 29'd0));
    // ST to HERE.
    rows.push_back(mk(1, 0, 0, 1, OP_ST, M_HR, 0, 0, 1, 29'd0));
    rows.push_back(mk(0, 1, 0, 0, OP_ST, M_HR, 0, 0, 1, ev(0, 0, 1, 0, AB_HERE, AL_ZERO, 16'd0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 0, 1, 0, OP_ST, M_HR, 0, 0, 1, ev(0, 0, 0, 0, AB_HERE, AL_ZERO, 16'd0, 0, 0, 0, 0)));
    // Not a load/store instruction: nothing happens.
    rows.push_back(mk(1, 0, 0, 0, OP_LD, M_INC, 1, 0, 1, 29'd0));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_INC, 1, 0, 1, 29'd0));
    rows.push_back(mk(0, 0, 1, 0, OP_LD, M_INC, 1, 0, 1, 29'd0));
    foreach (rows[i]) begin
      drive(rows[i]);
      want = sb.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL modes cycle=%0d got=%h exp=%h", i, outs, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    logic [28:0] want;
    rows.push_back(mk(1, 0, 0, 1, OP_LD, M_RR, 0, 0, 0, 29'd0));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_RR, 0, 0, 0, ev(1, 1, 0, 0, AB_ALUB, AL_ZERO, 16'd0, 0, 0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, OP_LD, M_RR, 0, 0, 0, ev(1, 1, 0, 0, AB_ALUB, AL_ZERO, 16'd0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      want = sb.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL reset_mid cycle=%0d got=%h exp=%h", i, outs, want);
      end
    end
    // Asynchronous reset in WAIT1, observed before the next clock edge.
    #1 RESET = 1'b1;
    #1;
    want = 29'd0;
    checks++;
    if (outs !== want) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", outs, want);
    end
    @(negedge CLK);
    EXECUTE = 1'b0;
    MEM_RDY = 1'b1;
    RESET   = 1'b0;
    run_ld_single("ld_after_reset");
  endtask

  initial begin
    test_reset();
    test_ld_single();
    test_st_wait();
    test_pair();
    test_timeout();
    test_modes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
